// File: rtl/equiv_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : equiv_mon_pkg
// Brief    : Shared state encoding and default sizing for the equivalence
//            mismatch monitor.
// Revision : 1.0 - initial release
// ============================================================================
package equiv_mon_pkg;

    localparam int c_DEF_WIDTH  = 91;
    localparam int c_DEF_WARMUP = 4;
    localparam int c_DEF_CNT_W  = 16;
    localparam int c_DEF_IDX_W  = 32;

    // Monitor phases: masked warm-up, armed, holding a record, record drained
    typedef enum logic [1:0] {
        WARM  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : equiv_mon_pkg
`default_nettype wire

// File: rtl/equiv_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : equiv_sat_counter
// Brief    : Up-counter with increment enable and synchronous clear that
//            holds at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module equiv_sat_counter
    import equiv_mon_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled events; stop at all-ones; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : equiv_sat_counter
`default_nettype wire

// File: rtl/equiv_mismatch_monitor.sv
`default_nettype none
// ============================================================================
// Module   : equiv_mismatch_monitor
// Brief    : Compares two candidate outputs on qualified cycles, counts
//            mismatches after a warm-up window, and offers the first failing
//            sample (index + XOR diff) on a valid/ready record port.
// Revision : 1.0 - initial release
// ============================================================================
module equiv_mismatch_monitor
    import equiv_mon_pkg::*;
#(
    parameter int          WIDTH  = c_DEF_WIDTH,
    parameter int unsigned WARMUP = c_DEF_WARMUP,
    parameter int          CNT_W  = c_DEF_CNT_W,
    parameter int          IDX_W  = c_DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    input  logic             sample_en,
    input  logic             clear,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [IDX_W-1:0] report_idx,
    output logic [WIDTH-1:0] report_diff
);

    // With no warm-up window the monitor comes out of reset already armed
    localparam state_t c_RST_STATE = (WARMUP == 0) ? ARMED : WARM;

    state_t           r_state;
    state_t           w_state_nx;

    logic [IDX_W-1:0] w_idx_cnt;
    logic [WIDTH-1:0] r_diff_q;
    logic             r_vld_q;
    logic [IDX_W-1:0] r_idx_q;

    logic             w_hit;
    logic             w_warm_done;
    logic             w_capture;
    logic             w_report_valid;

    logic             r_mismatch;
    logic             r_fail;
    logic [IDX_W-1:0] r_report_idx;
    logic [WIDTH-1:0] r_report_diff;

    // ------------------------------------------------------------------------
    // Sample index: position of the next qualified sample, saturating
    // ------------------------------------------------------------------------
    equiv_sat_counter #(
        .WIDTH (IDX_W)
    ) u_idx_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_inc   (sample_en),
        .o_count (w_idx_cnt)
    );

    // Stage 1: register the XOR difference and index of each qualified sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_q  <= 1'b0;
            r_diff_q <= '0;
            r_idx_q  <= '0;
        end else if (clear) begin
            r_vld_q  <= 1'b0;
            r_diff_q <= '0;
            r_idx_q  <= '0;
        end else begin
            r_vld_q <= sample_en;
            if (sample_en) begin
                r_diff_q <= y_1 ^ y_2;
                r_idx_q  <= w_idx_cnt;
            end
        end
    end

    // Stage 2 qualifier: a registered sample that differs, outside warm-up
    assign w_hit = r_vld_q && (|r_diff_q) && (r_state != WARM);

    // ------------------------------------------------------------------------
    // Warm-up: count registered samples while masked; leave WARM on the one
    // that completes the window so the next sample is the first armed one.
    // ------------------------------------------------------------------------
    generate
        if (WARMUP > 0) begin : g_warm
            localparam int c_WARM_W = $clog2(WARMUP + 1);

            logic [c_WARM_W-1:0] w_warm_cnt;

            equiv_sat_counter #(
                .WIDTH (c_WARM_W)
            ) u_warm_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_clear (clear),
                .i_inc   (r_vld_q && (r_state == WARM)),
                .o_count (w_warm_cnt)
            );

            assign w_warm_done = r_vld_q &&
                (({{(32-c_WARM_W){1'b0}}, w_warm_cnt} + 32'd1) >= WARMUP);
        end else begin : g_no_warm
            assign w_warm_done = 1'b1;
        end
    endgenerate

    // Mismatch count: every armed hit, saturating at all-ones
    equiv_sat_counter #(
        .WIDTH (CNT_W)
    ) u_mis_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_inc   (w_hit),
        .o_count (mismatch_count)
    );

    // FSM state register; clear returns to the post-reset state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RST_STATE;
        end else if (clear) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state: warm-up -> armed -> hold record -> drained
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            WARM:    if (w_warm_done)  w_state_nx = ARMED;
            ARMED:   if (w_hit)        w_state_nx = HOLD;
            HOLD:    if (report_ready) w_state_nx = DONE;
            DONE:    w_state_nx = DONE;
            default: w_state_nx = c_RST_STATE;
        endcase
    end

    // FSM outputs: valid is purely state-decoded, so ready never reaches it
    always_comb begin
        w_report_valid = (r_state == HOLD);
        w_capture      = (r_state == ARMED) && w_hit;
    end

    // Pulse per armed hit, sticky fail, and first-failure record capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch    <= 1'b0;
            r_fail        <= 1'b0;
            r_report_idx  <= '0;
            r_report_diff <= '0;
        end else if (clear) begin
            r_mismatch    <= 1'b0;
            r_fail        <= 1'b0;
            r_report_idx  <= '0;
            r_report_diff <= '0;
        end else begin
            r_mismatch <= w_hit;
            if (w_capture) begin
                r_fail        <= 1'b1;
                r_report_idx  <= r_idx_q;
                r_report_diff <= r_diff_q;
            end
        end
    end

    assign mismatch     = r_mismatch;
    assign fail         = r_fail;
    assign report_valid = w_report_valid;
    assign report_idx   = r_report_idx;
    assign report_diff  = r_report_diff;

endmodule : equiv_mismatch_monitor
`default_nettype wire

// File: tb/tb_equiv_mismatch_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_equiv_mismatch_monitor
// Brief    : Directed self-checking bench for equiv_mismatch_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_equiv_mismatch_monitor;
    import equiv_mon_pkg::*;

    localparam int c_WIDTH  = 91;
    localparam int c_WARMUP = 4;
    localparam int c_CNT_W  = 4;
    localparam int c_IDX_W  = 32;

    logic                clk;
    logic                rst_n;
    logic [c_WIDTH-1:0]  y_1;
    logic [c_WIDTH-1:0]  y_2;
    logic                sample_en;
    logic                clear;
    logic                mismatch;
    logic                fail;
    logic [c_CNT_W-1:0]  mismatch_count;
    logic                report_valid;
    logic                report_ready;
    logic [c_IDX_W-1:0]  report_idx;
    logic [c_WIDTH-1:0]  report_diff;

    int checks   = 0;
    int failures = 0;

    equiv_mismatch_monitor #(
        .WIDTH  (c_WIDTH),
        .WARMUP (c_WARMUP),
        .CNT_W  (c_CNT_W),
        .IDX_W  (c_IDX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .y_1            (y_1),
        .y_2            (y_2),
        .sample_en      (sample_en),
        .clear          (clear),
        .mismatch       (mismatch),
        .fail           (fail),
        .mismatch_count (mismatch_count),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_idx     (report_idx),
        .report_diff    (report_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [c_WIDTH-1:0] a, input logic [c_WIDTH-1:0] b);
        y_1       = a;
        y_2       = b;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
    endtask

    task automatic idle();
        sample_en = 1'b0;
        step();
    endtask

    logic [c_WIDTH-1:0] bit90;
    logic [c_WIDTH-1:0] eq_pat;
    logic [c_WIDTH-1:0] v;
    int                 pulses;

    initial begin
        rst_n        = 1'b0;
        y_1          = '0;
        y_2          = '0;
        sample_en    = 1'b0;
        clear        = 1'b0;
        report_ready = 1'b0;
        bit90        = '0;
        bit90[90]    = 1'b1;
        eq_pat       = 91'h5A5A_A5A5_1234;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_mismatch", 128'(mismatch), 128'(0));
        check("rst_fail",     128'(fail), 128'(0));
        check("rst_count",    128'(mismatch_count), 128'(0));
        check("rst_valid",    128'(report_valid), 128'(0));
        check("rst_idx",      128'(report_idx), 128'(0));
        check("rst_diff",     128'(report_diff), 128'(0));
        rst_n = 1'b1;
        step();

        // ---------------- warm-up masking: samples 0-3 differ ----------------
        for (int i = 0; i < 4; i++) begin
            sample(91'd0, 91'd1);
            check("warm_pulse", 128'(mismatch), 128'(0));
        end
        for (int i = 4; i < 10; i++) begin
            sample(eq_pat, eq_pat);
        end
        idle();
        idle();
        check("warm_count", 128'(mismatch_count), 128'(0));
        check("warm_fail",  128'(fail), 128'(0));
        check("warm_valid", 128'(report_valid), 128'(0));
        check("warm_state", 128'(dut.r_state), 128'(ARMED));

        // ---------------- first-failure capture + backpressure ----------------
        sample(bit90, 91'd0);                  // sample 10
        check("lat_no_pulse_yet", 128'(mismatch), 128'(0));
        sample(91'd5, 91'd4);                  // sample 11
        check("first_pulse",  128'(mismatch), 128'(1));
        check("first_count",  128'(mismatch_count), 128'(1));
        check("first_valid",  128'(report_valid), 128'(1));
        check("first_fail",   128'(fail), 128'(1));
        check("first_idx",    128'(report_idx), 128'(10));
        check("first_diff",   128'(report_diff), 128'(bit90));
        sample(eq_pat, eq_pat);                // sample 12
        check("b2b_pulse",    128'(mismatch), 128'(1));
        check("b2b_count",    128'(mismatch_count), 128'(2));
        check("b2b_idx_kept", 128'(report_idx), 128'(10));
        check("b2b_diff_kept",128'(report_diff), 128'(bit90));
        sample(eq_pat, eq_pat);                // sample 13
        check("eq_no_pulse",  128'(mismatch), 128'(0));
        sample(eq_pat, eq_pat);                // sample 14
        sample(91'd3, 91'd0);                  // sample 15
        idle();
        check("bp_pulse15",   128'(mismatch), 128'(1));
        check("bp_count",     128'(mismatch_count), 128'(3));
        idle();
        check("bp_idx",       128'(report_idx), 128'(10));
        check("bp_valid",     128'(report_valid), 128'(1));
        check("bp_state",     128'(dut.r_state), 128'(HOLD));

        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        check("hs_valid_low", 128'(report_valid), 128'(0));
        check("hs_state",     128'(dut.r_state), 128'(DONE));
        check("hs_idx_kept",  128'(report_idx), 128'(10));
        check("hs_fail_kept", 128'(fail), 128'(1));

        // ---------------- saturation: 20 armed mismatches, CNT_W=4 ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_state", 128'(dut.r_state), 128'(WARM));
        check("clr_count", 128'(mismatch_count), 128'(0));
        for (int i = 0; i < 4; i++) begin
            sample(eq_pat, eq_pat);
        end
        pulses = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                v = 91'(i + 1) << 3;
                sample(v, 91'd0);
            end else begin
                idle();
            end
            if (mismatch === 1'b1) pulses++;
        end
        check("sat_count",  128'(mismatch_count), 128'(15));
        check("sat_pulses", 128'(pulses), 128'(20));
        check("sat_idx",    128'(report_idx), 128'(4));
        check("sat_diff",   128'(report_diff), 128'(8));
        check("sat_fail",   128'(fail), 128'(1));
        check("sat_state",  128'(dut.r_state), 128'(HOLD));

        // ---------------- clear priority while in HOLD ----------------
        sample(91'd7, 91'd0);                  // registered; would hit next edge
        y_1       = 91'd9;
        y_2       = 91'd0;
        sample_en = 1'b1;
        clear     = 1'b1;
        step();
        clear     = 1'b0;
        sample_en = 1'b0;
        check("cp_mismatch", 128'(mismatch), 128'(0));
        check("cp_count",    128'(mismatch_count), 128'(0));
        check("cp_fail",     128'(fail), 128'(0));
        check("cp_valid",    128'(report_valid), 128'(0));
        check("cp_idx",      128'(report_idx), 128'(0));
        check("cp_diff",     128'(report_diff), 128'(0));
        check("cp_state",    128'(dut.r_state), 128'(WARM));
        for (int i = 0; i < 5; i++) begin
            sample(91'd1, 91'd2);              // samples 0-3 masked, 4 armed
            check("cp_rewarm_pulse", 128'(mismatch), 128'(0));
        end
        idle();
        check("cp_rearm_pulse", 128'(mismatch), 128'(1));
        check("cp_rearm_count", 128'(mismatch_count), 128'(1));
        check("cp_rearm_idx",   128'(report_idx), 128'(4));
        check("cp_rearm_diff",  128'(report_diff), 128'(3));
        check("cp_rearm_valid", 128'(report_valid), 128'(1));

        // ---------------- asynchronous reset mid-HOLD ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 128'(report_valid), 128'(0));
        check("ar_fail",  128'(fail), 128'(0));
        check("ar_count", 128'(mismatch_count), 128'(0));
        check("ar_idx",   128'(report_idx), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        check("ar_state", 128'(dut.r_state), 128'(WARM));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_equiv_mismatch_monitor
`default_nettype wire
